// File: rtl/lamp_pkg.sv
// Shared definitions for the RGY lamp sequencer.
//   phase_t    : 2-bit phase/state encoding, also driven out on the phase port
//   LAMP_*     : lamp drive codes, bit order {R,G,Y}
//   lamp_code  : maps a phase plus the flash "lit" half into a lamp code
package lamp_pkg;

    typedef enum logic [1:0] {
        PH_RED    = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_FLASH  = 2'd3
    } phase_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;
    localparam logic [2:0] LAMP_OFF    = 3'b000;

    function automatic logic [2:0] lamp_code(input phase_t ph, input logic lit);
        logic [2:0] code;
        code = LAMP_RED;
        case (ph)
            PH_RED:    code = LAMP_RED;
            PH_GREEN:  code = LAMP_GREEN;
            PH_YELLOW: code = LAMP_YELLOW;
            PH_FLASH:  code = lit ? LAMP_YELLOW : LAMP_OFF;
            default:   code = LAMP_RED;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Dwell down-counter shared by all phases.
//   clk, rst_n  : clock, synchronous active-low reset (loads RST_VAL)
//   load_i      : load load_val_i this cycle (takes priority over counting)
//   load_val_i  : value to load, normally <PHASE>_TICKS-1
//   done_o      : counter is at zero; the owning phase ends at the next edge
//   count_o     : current count (used to derive elapsed GREEN cycles)
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            // Holds at zero so a missed load can never wrap into a long dwell.
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done_o  = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/lamp_sequencer_ctrl.sv
// Phase controller for a 3-lamp RGY signal head.
// Sequences RED -> GREEN -> YELLOW with per-phase dwell, cuts GREEN short on a
// pedestrian request once GREEN_MIN cycles have elapsed, and flashes yellow in
// maintenance mode.
//   clk, rst_n  : clock, synchronous active-low reset
//   ped_req     : pedestrian request (level or pulse)
//   maint       : 1 = flashing-yellow maintenance mode
//   light       : registered lamp drive {R,G,Y}
//   phase       : current state (0 RED, 1 GREEN, 2 YELLOW, 3 FLASH)
//   ped_ack     : one-cycle pulse when a pedestrian request is served
//   cycle_done  : one-cycle pulse on the first RED cycle after YELLOW
module lamp_sequencer_ctrl
    import lamp_pkg::*;
#(
    parameter int RED_TICKS    = 5,
    parameter int GREEN_TICKS  = 4,
    parameter int GREEN_MIN    = 2,
    parameter int YELLOW_TICKS = 2,
    parameter int FLASH_TICKS  = 3,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ped_req,
    input  logic       maint,
    output logic [2:0] light,
    output logic [1:0] phase,
    output logic       ped_ack,
    output logic       cycle_done
);

    localparam logic [CNT_W-1:0] RED_LD    = CNT_W'(RED_TICKS - 1);
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_TICKS - 1);

    phase_t           state_q, state_d;
    logic             pend_q, pend_d;
    logic             lit_q, lit_d;
    logic             ack_q, ack_d;
    logic             cdone_q, cdone_d;
    logic [2:0]       light_q, light_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_done;
    logic [CNT_W-1:0] tmr_count;

    logic [CNT_W-1:0] green_elapsed;
    logic             pend_eff;
    logic             green_cut;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (RED_LD)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .done_o     (tmr_done),
        .count_o    (tmr_count)
    );

    // Elapsed GREEN cycles before the current one; only meaningful in GREEN.
    assign green_elapsed = GREEN_LD - tmr_count;
    // A request arriving this very cycle counts, so a pulse on an eligible
    // GREEN cycle ends GREEN at the next edge.
    assign pend_eff      = pend_q | ped_req;
    assign green_cut     = pend_eff && (green_elapsed >= CNT_W'(GREEN_MIN));

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        lit_d        = lit_q;
        ack_d        = 1'b0;
        cdone_d      = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = RED_LD;

        if (maint) begin
            pend_d = 1'b0;
            if (state_q != PH_FLASH) begin
                state_d      = PH_FLASH;
                lit_d        = 1'b1;
                tmr_load     = 1'b1;
                tmr_load_val = FLASH_LD;
            end else if (tmr_done) begin
                lit_d        = ~lit_q;
                tmr_load     = 1'b1;
                tmr_load_val = FLASH_LD;
            end
        end else begin
            case (state_q)
                PH_RED: begin
                    // RED already serves the pedestrian: acknowledge, never latch.
                    ack_d = ped_req;
                    if (tmr_done) begin
                        state_d      = PH_GREEN;
                        tmr_load     = 1'b1;
                        tmr_load_val = GREEN_LD;
                    end
                end
                PH_GREEN: begin
                    pend_d = pend_eff;
                    if (tmr_done || green_cut) begin
                        state_d      = PH_YELLOW;
                        tmr_load     = 1'b1;
                        tmr_load_val = YELLOW_LD;
                    end
                end
                PH_YELLOW: begin
                    pend_d = pend_eff;
                    if (tmr_done) begin
                        state_d      = PH_RED;
                        tmr_load     = 1'b1;
                        tmr_load_val = RED_LD;
                        cdone_d      = 1'b1;
                        ack_d        = pend_eff;
                        pend_d       = 1'b0;
                    end
                end
                PH_FLASH: begin
                    // Leaving maintenance: fresh RED, no cycle_done.
                    state_d      = PH_RED;
                    pend_d       = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_load_val = RED_LD;
                end
                default: begin
                    state_d      = PH_RED;
                    pend_d       = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_load_val = RED_LD;
                end
            endcase
        end

        light_d = lamp_code(state_d, lit_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= PH_RED;
            pend_q  <= 1'b0;
            lit_q   <= 1'b1;
            ack_q   <= 1'b0;
            cdone_q <= 1'b0;
            light_q <= LAMP_RED;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            lit_q   <= lit_d;
            ack_q   <= ack_d;
            cdone_q <= cdone_d;
            light_q <= light_d;
        end
    end

    assign light      = light_q;
    assign phase      = state_q;
    assign ped_ack    = ack_q;
    assign cycle_done = cdone_q;

endmodule
